sprite_eval_controller: RTL
===========================

Name: sprite_eval_controller

Overview:
- Per-scanline sprite evaluation sequencer for the PPU.
- Drives the 256-byte primary OAM read address and sequences writes into the 32-byte secondary OAM.
- Phase 1 clears secondary OAM to 0xFF. Phase 2 scans all 64 sprites, copies up to 8 in-range sprites (4 bytes each) and flags overflow and sprite-0 presence for the renderer.

Parameters:
- SPRITE_LIMIT, 8, maximum sprites copied per scanline; must be 8 to match the 32-byte secondary OAM.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clock_EN  in  1  PPU dot enable; all state advances only when high
- start  in  1  begin evaluation for scanline; sampled only in IDLE with clock_EN
- scanline  in  8  target scanline number
- sprite_size_16  in  1  0 = 8-pixel-tall sprites, 1 = 16-pixel-tall sprites
- oam_data  in  8  primary OAM read data (combinational read of oam_address)
- oam_address  out  8  primary OAM read address
- sec_write  out  1  secondary OAM write strobe
- sec_address  out  5  secondary OAM address
- sec_data  out  8  secondary OAM write data
- busy  out  1  high in any state except IDLE
- done  out  1  one enabled-cycle pulse in DONE
- sprite_count  out  4  sprites copied this scanline, 0..8
- sprite_overflow  out  1  a 9th in-range sprite was found
- sprite0_in_range  out  1  sprite 0 was copied this scanline

Behaviour:
- Reset values: oam_address 0, sec_write 0, sec_address 0, busy 0, done 0, sprite_count 0, sprite_overflow 0, sprite0_in_range 0. sec_data is 0xFF while in IDLE and CLEAR.
- Reset mid-operation aborts immediately to IDLE. Secondary OAM contents are then undefined.
- States: IDLE, CLEAR, EVAL_Y, COPY (byte index k = 1..3), OVF_SCAN, DONE. Internal counters: n (6-bit sprite index), c (4-bit copy count), m (2-bit byte offset).
- No state, counter or flag changes on any cycle where clock_EN is low. Outputs hold.
- IDLE: when start is high, go to CLEAR. On entry, clear n, c, m, sprite_count, sprite_overflow and sprite0_in_range. start while busy is ignored.
- CLEAR: 32 enabled cycles; sec_address = 0..31, sec_write = 1, sec_data = 0xFF. Then go to EVAL_Y with n = 0.
- Range test, 9-bit arithmetic: diff = {0,scanline} - {0,oam_data}. In range iff diff is non-negative and diff < 8, or diff < 16 when sprite_size_16 is set. Y = 0xFF is never in range.
- EVAL_Y:
  - oam_address = {n,2'b00}, sec_address = {c[2:0],2'b00}, sec_data = oam_data.
  - sec_write = in_range, in the same cycle.
  - If in range, go to COPY with k = 1, and set sprite0_in_range when n = 0.
  - Otherwise n++. If n wraps from 63, go to DONE.
- COPY: oam_address = {n,k}, sec_address = {c[2:0],k}, sec_write = 1, sec_data = oam_data.
  - After k = 3: c++ and n++.
  - If n wraps, go to DONE. Else if c = 8, go to OVF_SCAN. Else go to EVAL_Y.
- Latency per sprite: not in range 1 cycle; in range 4 cycles.
- OVF_SCAN: oam_address = {n,m}, sec_write = 0.
  - If in range, set sprite_overflow and go to DONE.
  - Otherwise n++. If n wraps, go to DONE.
  - m stays 0 in this mode (see Optional Feature).
- DONE: done = 1, busy = 1 for one enabled cycle, then IDLE.
- sprite_count, sprite_overflow and sprite0_in_range hold until the next accepted start.
- Minimum start-to-IDLE with no sprites in range: 1 (IDLE) + 32 (CLEAR) + 64 (EVAL_Y) + 1 (DONE) enabled cycles.

Optional Feature:
- Macro: SPRITE_OVERFLOW_BUG_EN.
- When defined, OVF_SCAN reproduces the original hardware's diagonal-read bug. On a not-in-range result both n++ and m++ (m wraps mod 4), so the Y comparison reads byte m of sprite n.
- When undefined, m is held at 0 and overflow detection is exact.

Test Plan:
- start, scanline=50, all Y=0xFF: 32 writes of 0xFF to sec 0..31, no further sec_write, done at enabled cycle 97, sprite_count=0, overflow=0.
- Sprite 0 = {Y=45,0x12,0x03,0x80}, scanline=50, 8x8: sec[0..3] = 45,0x12,0x03,0x80; sprite0_in_range=1; sprite_count=1.
- Same sprite 0, scanline=53 with sprite_size_16=0 -> not copied; with sprite_size_16=1 -> copied. Boundary: diff=7 copied, diff=8 not copied in 8x8 mode.
- Sprites 0..9 all Y=50, scanline=50: exactly 8 copied, sec bytes match sprites 0..7, sprite_overflow=1, done asserted once after the overflow hit.
- clock_EN toggling 1/3 duty during evaluation: identical sec write sequence and flags to the always-enabled run.
- reset_n asserted mid-COPY: all outputs at reset values immediately. New start works normally.
- With SPRITE_OVERFLOW_BUG_EN: sprites 0..7 Y=50, sprite 8 Y=0xFF, sprite 9 byte1=50 -> overflow=1. Without the macro -> overflow=0.

Source files
------------

// File: rtl/sprite_eval_controller.sv
// -----------------------------------------------------------------------------
// sprite_eval_controller
//
// Per-scanline sprite evaluation sequencer. On an accepted start it fills the
// 32-byte secondary OAM with 0xFF, then walks the 64 primary OAM entries and
// copies up to SPRITE_LIMIT in-range sprites (4 bytes each) into secondary OAM.
// After the secondary OAM is full it keeps scanning for a 9th in-range sprite
// to raise sprite_overflow.
//
// Optional feature macro: SPRITE_OVERFLOW_BUG_EN
//   When defined, the overflow scan reproduces the original hardware's
//   diagonal read: each miss advances both the sprite index n and the byte
//   offset m, so the "Y" compared is byte m of sprite n. When undefined, m
//   stays 0 and overflow detection is exact.
//
// Ports
//   clock            system clock
//   reset_n          asynchronous active-low reset
//   clock_EN         PPU dot enable; nothing advances while low, outputs hold
//   start            begin evaluation; only sampled in IDLE with clock_EN
//   scanline[7:0]    target scanline
//   sprite_size_16   0 = 8-pixel-tall sprites, 1 = 16-pixel-tall sprites
//   oam_data[7:0]    primary OAM read data (combinational read of oam_address)
//   oam_address[7:0] primary OAM read address
//   sec_write        secondary OAM write strobe
//   sec_address[4:0] secondary OAM write address
//   sec_data[7:0]    secondary OAM write data
//   busy             high in every state except IDLE
//   done             high in DONE (one enabled cycle)
//   sprite_count[3:0] sprites copied this scanline (0..8)
//   sprite_overflow  a further in-range sprite was found after 8 copies
//   sprite0_in_range sprite 0 was copied this scanline
//   state_dbg[2:0]   current FSM state: 0 IDLE, 1 CLEAR, 2 EVAL_Y, 3 COPY,
//                    4 OVF_SCAN, 5 DONE
//
// Handshake: sec_write/sec_address/sec_data form a valid-only write port with
// no back-pressure. A write takes place on a rising clock edge where both
// sec_write and clock_EN are high; while clock_EN is low the strobe and its
// address/data hold their values and must not be counted as new writes.
// -----------------------------------------------------------------------------
module sprite_eval_controller #(
  parameter int SPRITE_LIMIT = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_EN,
  input  logic       start,
  input  logic [7:0] scanline,
  input  logic       sprite_size_16,
  input  logic [7:0] oam_data,
  output logic [7:0] oam_address,
  output logic       sec_write,
  output logic [4:0] sec_address,
  output logic [7:0] sec_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] sprite_count,
  output logic       sprite_overflow,
  output logic       sprite0_in_range,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    EVAL_Y   = 3'd2,
    COPY     = 3'd3,
    OVF_SCAN = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t     state;
  logic [5:0] n;   // sprite index; doubles as the clear index in CLEAR
  logic [3:0] c;   // sprites copied
  logic [1:0] m;   // byte offset used by the overflow scan
  logic [1:0] k;   // byte index within a sprite during COPY

  // 9-bit subtraction: bit 8 set means the sprite starts below the scanline.
  logic [8:0] diff;
  logic       in_range;

  assign diff     = {1'b0, scanline} - {1'b0, oam_data};
  // Y = 0xFF marks an empty slot and must never match, even on scanline 255.
  assign in_range = (oam_data != 8'hFF) && !diff[8] &&
                    (diff[7:0] < (sprite_size_16 ? 8'd16 : 8'd8));

  // Outputs are decoded from registered state; only the EVAL_Y/COPY data path
  // passes oam_data straight through so a byte is copied in the cycle it is read.
  always_comb begin
    oam_address = 8'd0;
    sec_write   = 1'b0;
    sec_address = 5'd0;
    sec_data    = 8'hFF;
    case (state)
      CLEAR: begin
        sec_address = n[4:0];
        sec_write   = 1'b1;
      end
      EVAL_Y: begin
        oam_address = {n, 2'b00};
        sec_address = {c[2:0], 2'b00};
        sec_data    = oam_data;
        sec_write   = in_range;
      end
      COPY: begin
        oam_address = {n, k};
        sec_address = {c[2:0], k};
        sec_data    = oam_data;
        sec_write   = 1'b1;
      end
      OVF_SCAN: begin
        oam_address = {n, m};
      end
      default: ;
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign sprite_count = c;
  assign state_dbg    = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      n                <= 6'd0;
      c                <= 4'd0;
      m                <= 2'd0;
      k                <= 2'd0;
      sprite_overflow  <= 1'b0;
      sprite0_in_range <= 1'b0;
    end else if (clock_EN) begin
      case (state)
        IDLE: begin
          if (start) begin
            state            <= CLEAR;
            n                <= 6'd0;
            c                <= 4'd0;
            m                <= 2'd0;
            k                <= 2'd0;
            sprite_overflow  <= 1'b0;
            sprite0_in_range <= 1'b0;
          end
        end
        CLEAR: begin
          if (n == 6'd31) begin
            n     <= 6'd0;
            state <= EVAL_Y;
          end else begin
            n <= n + 6'd1;
          end
        end
        EVAL_Y: begin
          if (in_range) begin
            state <= COPY;
            k     <= 2'd1;
            if (n == 6'd0) sprite0_in_range <= 1'b1;
          end else begin
            n <= n + 6'd1;
            if (n == 6'd63) state <= DONE;
          end
        end
        COPY: begin
          if (k == 2'd3) begin
            k <= 2'd0;
            c <= c + 4'd1;
            n <= n + 6'd1;
            // A wrap of n wins over a full secondary OAM: nothing left to scan.
            if (n == 6'd63)                        state <= DONE;
            else if (c == 4'(SPRITE_LIMIT - 1))    state <= OVF_SCAN;
            else                                   state <= EVAL_Y;
          end else begin
            k <= k + 2'd1;
          end
        end
        OVF_SCAN: begin
          if (in_range) begin
            sprite_overflow <= 1'b1;
            state           <= DONE;
          end else begin
            n <= n + 6'd1;
`ifdef SPRITE_OVERFLOW_BUG_EN
            m <= m + 2'd1;
`else
            m <= 2'd0;
`endif
            if (n == 6'd63) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
